div_bcd_out: RTL

DIV_BCD_OUT -- requirements
Module: div_bcd_out

---
 rtl/div_pkg.sv | 16 +
 rtl/div_bcd_out_if.sv | 22 ++
 rtl/bcd_dd_core.sv | 35 +++
 rtl/div_bcd_out.sv | 64 ++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, blank nibble and digit sizing helper for the BCD output stage
package div_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam logic [3:0] BCD_BLANK = 4'hF;
   function automatic int digits_needed(input int width);
      longint v;
      int n;
      v = (longint'(1) << width) - 64'sd1;
      n = 1;
      while (v >= 64'sd10) begin
         v = v / 64'sd10;
         n++;
      end
      return n;
   endfunction
endpackage

// File: rtl/div_bcd_out_if.sv
// div_bcd_out_if: divider-result in / BCD-result out handshake bundle
interface div_bcd_out_if #(parameter int WIDTH = 4, parameter int DIGITS = 2);
   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      in_quot;
   logic [WIDTH-1:0]      in_rem;
   logic                  in_dbz;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   out_quot_bcd;
   logic [4*DIGITS-1:0]   out_rem_bcd;
   logic                  out_dbz;
   logic                  busy;
   modport master (
      output in_valid, in_quot, in_rem, in_dbz, out_ready,
      input  in_ready, out_valid, out_quot_bcd, out_rem_bcd, out_dbz, busy
   );
   modport slave (
      input  in_valid, in_quot, in_rem, in_dbz, out_ready,
      output in_ready, out_valid, out_quot_bcd, out_rem_bcd, out_dbz, busy
   );
endinterface

// File: rtl/bcd_dd_core.sv
// bcd_dd_core: one field of a double-dabble converter; load clears the BCD side, step does add-3 then shift
module bcd_dd_core #(
   parameter int WIDTH  = 4,
   parameter int DIGITS = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic                step,
   input  logic [WIDTH-1:0]    din,
   output logic [4*DIGITS-1:0] nxt
);
   logic [WIDTH-1:0]           bin;
   logic [4*DIGITS-1:0]        bcd;
   logic [4*DIGITS-1:0]        adj;
   logic [4*DIGITS+WIDTH-1:0]  sh;
   always_comb begin
      adj = bcd;
      for (int i = 0; i < DIGITS; i++)
         adj[4*i+:4] = (bcd[4*i+:4] >= 4'd5) ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
      sh = {adj, bin} << 1;
   end
   assign nxt = sh[WIDTH+:4*DIGITS];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bin <= '0;
         bcd <= '0;
      end else if (load) begin
         bin <= din;
         bcd <= '0;
      end else if (step) begin
         bin <= sh[WIDTH-1:0];
         bcd <= nxt;
      end
endmodule

// File: rtl/div_bcd_out.sv
// div_bcd_out: converts a divider's quotient/remainder to BCD over WIDTH shift cycles, blanking on divide-by-zero
module div_bcd_out
   import div_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int DIGITS = 2
) (
   input logic         clk,
   input logic         rst_n,
   div_bcd_out_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int OW = 4 * DIGITS;
   if (DIGITS < digits_needed(WIDTH)) begin : g_bad_digits
      $error("div_bcd_out: DIGITS too small to hold 2^WIDTH-1");
   end
   state_t          state, state_d;
   logic [CW-1:0]   cnt;
   logic            dbz, dbz_out, load, step, last;
   logic [OW-1:0]   q_nxt, r_nxt, q_out, r_out;
   assign last = cnt == CW'(WIDTH - 1);
   always_comb begin
      load    = state == IDLE && bus.in_valid;
      step    = state == SHIFT;
      state_d = load ? SHIFT :
                (step && last) ? DONE :
                (state == DONE && bus.out_ready) ? IDLE : state;
   end
   // outputs are loaded only on the final shift so they stay put while the next result converts
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         dbz     <= 1'b0;
         dbz_out <= 1'b0;
         q_out   <= '0;
         r_out   <= '0;
      end else begin
         state <= state_d;
         if (load) begin
            cnt <= '0;
            dbz <= bus.in_dbz;
         end else if (step) begin
            cnt <= (cnt < CW'(WIDTH)) ? cnt + CW'(1) : cnt;
            if (last) begin
               q_out   <= dbz ? {DIGITS{BCD_BLANK}} : q_nxt;
               r_out   <= dbz ? {DIGITS{BCD_BLANK}} : r_nxt;
               dbz_out <= dbz;
            end
         end
      end
   bcd_dd_core #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_quot (
      .clk(clk), .rst_n(rst_n), .load(load), .step(step), .din(bus.in_quot), .nxt(q_nxt)
   );
   bcd_dd_core #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_rem (
      .clk(clk), .rst_n(rst_n), .load(load), .step(step), .din(bus.in_rem), .nxt(r_nxt)
   );
   assign bus.in_ready     = state == IDLE;
   assign bus.out_valid    = state == DONE;
   assign bus.busy         = state == SHIFT;
   assign bus.out_quot_bcd = q_out;
   assign bus.out_rem_bcd  = r_out;
   assign bus.out_dbz      = dbz_out;
endmodule
